// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 unsigned shift-add multiplier that borrows the shared
// 8-bit combinational ALU (no hardware multiplier) for its additions and
// shifts. While Busy is high the external ALU mux routes AluA/AluB/AluOp
// from this block, and AluOut comes straight back in the same cycle.
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_SHR = 4'b0101,
  parameter int         ITER   = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Abort,
  input  logic [7:0]  InA,
  input  logic [7:0]  InB,
  output logic [7:0]  AluA,
  output logic [7:0]  AluB,
  output logic [3:0]  AluOp,
  input  logic [7:0]  AluOut,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Product
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  Mcand;
  logic [7:0]  Hi;
  logic [7:0]  Lo;
  logic        Carry;
  logic [2:0]  Cnt;

  // The ALU adds without carry-out, so an unsigned wrap shows up as the
  // sum being smaller than the value it started from.
  function automatic logic add_wrapped(input logic [7:0] sum,
                                       input logic [7:0] base);
    return (sum < base);
  endfunction

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus combinational ALU drive, Busy and Done.
  always_comb begin
    state_next = state;
    AluA       = 8'd0;
    AluB       = 8'd0;
    AluOp      = OP_ADD;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_next = S_ADD;
        end
      end
      S_ADD: begin
        Busy       = 1'b1;
        AluA       = Hi;
        AluB       = Mcand;
        AluOp      = OP_ADD;
        // The add cycle always runs, even when Lo[0]=0, so latency is fixed.
        state_next = Abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        Busy  = 1'b1;
        AluA  = Hi;
        AluOp = OP_SHR;
        if (Abort) begin
          state_next = S_IDLE;
        end else if (Cnt == CNT_LAST) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ADD;
        end
      end
      S_DONE: begin
        Busy       = 1'b1;
        // An abort in the final cycle suppresses the completion pulse.
        Done       = ~Abort;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, partial-product accumulate, shift, and result.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mcand   <= 8'd0;
      Hi      <= 8'd0;
      Lo      <= 8'd0;
      Carry   <= 1'b0;
      Cnt     <= 3'd0;
      Product <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            Mcand <= InA;
            Lo    <= InB;
            Hi    <= 8'd0;
            Carry <= 1'b0;
            Cnt   <= 3'd0;
          end
        end
        S_ADD: begin
          if (!Abort) begin
            if (Lo[0]) begin
              Hi    <= AluOut;
              Carry <= add_wrapped(AluOut, Hi);
            end else begin
              Carry <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          if (!Abort) begin
            // The carry from the add re-enters as bit 7 of the shifted Hi,
            // and Hi's outgoing LSB moves into the top of Lo.
            Hi    <= {Carry, AluOut[6:0]};
            Lo    <= {Hi[0], Lo[7:1]};
            Carry <= 1'b0;
            Cnt   <= Cnt + 3'd1;
          end
        end
        S_DONE: begin
          if (!Abort) begin
            Product <= {Hi, Lo};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed-vector bench with a scoreboard queue of expected
// products and a separate monitor that checks Product on the cycle after Done.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SHR = 4'b0101;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Abort;
  logic [7:0]  InA;
  logic [7:0]  InB;
  logic [7:0]  AluA;
  logic [7:0]  AluB;
  logic [3:0]  AluOp;
  logic [7:0]  AluOut;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];
  logic        done_q;

  alu_mul_seq #(.OP_ADD(OP_ADD), .OP_SHR(OP_SHR), .ITER(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Abort   (Abort),
    .InA     (InA),
    .InB     (InB),
    .AluA    (AluA),
    .AluB    (AluB),
    .AluOp   (AluOp),
    .AluOut  (AluOut),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  // Behavioural model of the shared combinational ALU.
  always_comb begin
    if (AluOp == OP_SHR) AluOut = {1'b0, AluA[7:1]};
    else                 AluOut = AluA + AluB;
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: Product is checked on the cycle following a Done pulse.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      done_q <= 1'b0;
    end else begin
      if (done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(Product), 32'hFFFF_FFFF);
        end else begin
          check("product", 32'(Product), 32'(sb.pop_front()));
        end
      end
      done_q <= Done;
    end
  end

  // Runs one operation from a Start pulse until Busy drops. Optional mid-op
  // restart (ignored by the DUT) and abort at a given busy-cycle index.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int restart_at,
                        input int abort_at, input int exp_busy,
                        input int exp_dones, input string tag);
    int busy_cnt = 0;
    int dones = 0;
    int done_at = -1;
    logic op_ok = 1'b1;
    InA = a; InB = b; Start = 1'b1;
    if (exp_dones > 0) sb.push_back(exp);
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!Busy) break;
      busy_cnt++;
      if (Done) begin dones++; done_at = c; end
      if (c < 16 && abort_at < 0) begin
        if (AluOp !== ((c % 2 == 0) ? OP_ADD : OP_SHR)) op_ok = 1'b0;
      end
      if (c == restart_at) begin InA = 8'hFF; InB = 8'hFF; Start = 1'b1; end
      if (c == abort_at) Abort = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      Abort = 1'b0;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_done_count"}, 32'(dones), 32'(exp_dones));
    if (exp_dones > 0) begin
      check({tag, "_done_cycle"}, 32'(done_at), 32'd16);
      if (abort_at < 0) check({tag, "_aluop_seq"}, 32'(op_ok), 32'd1);
    end
    @(negedge Clk);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    Start   = 1'($urandom);
    Abort   = 1'($urandom);
    InA     = 8'($urandom);
    InB     = 8'($urandom);
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_product", 32'(Product), 32'd0);
    check("rst_aluop", 32'(AluOp), 32'(OP_ADD));
    check("rst_alua", 32'(AluA), 32'd0);
    check("rst_alub", 32'(AluB), 32'd0);
    Start = 1'b0; Abort = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_op(8'd13,  8'd11,  16'h008F, -1, -1, 17, 1, "m13x11");
    run_op(8'd255, 8'd255, 16'hFE01, -1, -1, 17, 1, "m255x255");
    run_op(8'd128, 8'd2,   16'h0100, -1, -1, 17, 1, "m128x2");
    run_op(8'h00,  8'hA5,  16'h0000, -1, -1, 17, 1, "m0xA5");
    run_op(8'h5A,  8'h00,  16'h0000, -1, -1, 17, 1, "m5Ax0");
    run_op(8'h81,  8'h7F,  16'h3FFF, -1, -1, 17, 1, "m81x7F");
    run_op(8'd7,   8'd9,   16'h003F,  6, -1, 17, 1, "restart");

    // Abort at busy-cycle 5: no Done, Product keeps the prior result.
    run_op(8'h10, 8'h10, 16'h0000, -1, 5, 6, 0, "abort");
    check("abort_product_kept", 32'(Product), 32'h003F);

    // Reset in the middle of an operation.
    InA = 8'h33; InB = 8'h44; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_product", 32'(Product), 32'd0);
    check("midrst_aluop", 32'(AluOp), 32'(OP_ADD));
    check("midrst_alua", 32'(AluA), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_op(8'd200, 8'd100, 16'h4E20, -1, -1, 17, 1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
